// File: rtl/fifo_v3.sv
// Single-clock FIFO with registered output (no fall-through), exact DEPTH capacity,
// synchronous flush and asynchronous active-low reset.
module fifo_v3 #(
    parameter bit  FALL_THROUGH = 1'b0,
    parameter int  DEPTH        = 4,
    parameter type dtype        = logic,
    localparam int CntWidth     = $clog2(DEPTH + 1),
    localparam int AddrWidth    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [CntWidth-1:0] usage_o,
    input  dtype                data_i,
    input  logic                push_i,
    output dtype                data_o,
    input  logic                pop_i
);

    dtype                 mem_q [DEPTH];
    logic [AddrWidth-1:0] rd_ptr_q;
    logic [AddrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 do_push;
    logic                 do_pop;

    if (FALL_THROUGH) begin : g_no_fall_through
        $error("fifo_v3: FALL_THROUGH mode is not implemented");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("fifo_v3: DEPTH must be at least 1");
    end

    function automatic logic [AddrWidth-1:0] wrap_inc(input logic [AddrWidth-1:0] p);
        return (p == AddrWidth'(DEPTH - 1)) ? '0 : p + AddrWidth'(1);
    endfunction

    assign full_o  = (cnt_q == CntWidth'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wrap_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= wrap_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/stream_fifo_arb.sv
// Per-channel input FIFOs merged onto one output stream by a round-robin arbiter
// whose choice is held stable while the output is stalled.
module stream_fifo_arb #(
    parameter int  NumChan  = 4,
    parameter int  Depth    = 4,
    parameter type T        = logic,
    localparam int IdxWidth = (NumChan > 1) ? $clog2(NumChan) : 1,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  T              [NumChan-1:0]       inp_data_i,
    input  logic          [NumChan-1:0]       inp_valid_i,
    output logic          [NumChan-1:0]       inp_ready_o,
    output T                                  oup_data_o,
    output logic          [IdxWidth-1:0]      oup_idx_o,
    output logic                              oup_valid_o,
    input  logic                              oup_ready_i,
    output logic [NumChan-1:0][CntWidth-1:0]  usage_o
);

    if (NumChan < 1) begin : g_bad_chan
        $error("stream_fifo_arb: NumChan must be at least 1");
    end
    if (Depth < 1) begin : g_bad_depth
        $error("stream_fifo_arb: Depth must be at least 1");
    end

    logic [NumChan-1:0]  full;
    logic [NumChan-1:0]  empty;
    logic [NumChan-1:0]  push;
    logic [NumChan-1:0]  pop;
    T     [NumChan-1:0]  head;
    logic [IdxWidth-1:0] ptr_q;
    logic [IdxWidth-1:0] lock_idx_q;
    logic                lock_q;
    logic [IdxWidth-1:0] rr_idx;
    logic [IdxWidth-1:0] rr_cand;
    logic [IdxWidth-1:0] sel_idx;
    logic                handshake;

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        fifo_v3 #(
            .FALL_THROUGH (1'b0),
            .DEPTH        (Depth),
            .dtype        (T)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (flush_i),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .usage_o (usage_o[c]),
            .data_i  (inp_data_i[c]),
            .push_i  (push[c]),
            .data_o  (head[c]),
            .pop_i   (pop[c])
        );
    end

    // Ready depends only on fill state and flush, never on the incoming valid.
    assign inp_ready_o = ~full & {NumChan{~flush_i}};
    assign push        = inp_valid_i & inp_ready_o;

    // Scan downwards so the last hit is the first non-empty channel from the pointer.
    always_comb begin
        rr_idx  = ptr_q;
        rr_cand = '0;
        for (int i = NumChan - 1; i >= 0; i--) begin
            rr_cand = ((int'(ptr_q) + i) >= NumChan) ? IdxWidth'(int'(ptr_q) + i - NumChan)
                                                     : IdxWidth'(int'(ptr_q) + i);
            if (!empty[rr_cand]) begin
                rr_idx = rr_cand;
            end
        end
    end

    assign sel_idx     = lock_q ? lock_idx_q : rr_idx;
    assign oup_valid_o = !flush_i && !empty[sel_idx];
    assign oup_idx_o   = oup_valid_o ? sel_idx : '0;
    assign oup_data_o  = oup_valid_o ? head[sel_idx] : '0;
    assign handshake   = oup_valid_o && oup_ready_i;

    always_comb begin
        pop = '0;
        if (handshake) begin
            pop[sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (flush_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= oup_valid_o && !oup_ready_i;
            lock_idx_q <= sel_idx;
            if (handshake) begin
                ptr_q <= (sel_idx == IdxWidth'(NumChan - 1)) ? '0 : sel_idx + IdxWidth'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_fifo_arb.sv
// Directed scenarios plus a randomized run compared against a queue-based model
// of the merged stream (4 channels, depth 2, byte payload).
module tb_stream_fifo_arb;

    localparam int NCH = 4;
    localparam int DEP = 2;
    typedef logic [7:0] data_t;
    typedef data_t data_q_t[$];

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    flush;
    data_t [NCH-1:0]         inp_data;
    logic  [NCH-1:0]         inp_valid;
    logic  [NCH-1:0]         inp_ready;
    data_t                   oup_data;
    logic  [1:0]             oup_idx;
    logic                    oup_valid;
    logic                    oup_ready;
    logic  [NCH-1:0][1:0]    usage;

    int checks = 0;
    int errors = 0;

    data_q_t mq [NCH];
    int      m_ptr;
    int      m_held_ch;
    bit      m_held;

    always #5 clk = ~clk;

    stream_fifo_arb #(
        .NumChan (NCH),
        .Depth   (DEP),
        .T       (data_t)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .inp_data_i  (inp_data),
        .inp_valid_i (inp_valid),
        .inp_ready_o (inp_ready),
        .oup_data_o  (oup_data),
        .oup_idx_o   (oup_idx),
        .oup_valid_o (oup_valid),
        .oup_ready_i (oup_ready),
        .usage_o     (usage)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inp_valid = '0;
        inp_data  = '0;
        oup_ready = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", oup_valid); end
        checks++; if (usage !== '0) begin errors++; $display("[TB] FAIL reset_usage: got %h expected 0", usage); end
        checks++; if (oup_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", oup_data); end
        checks++; if (oup_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", oup_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (inp_ready !== 4'hF) begin errors++; $display("[TB] FAIL post_reset_ready: got %b expected 1111", inp_ready); end
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_valid: got %b expected 0", oup_valid); end
    endtask

    task automatic test_single_push();
        do_flush();
        inp_valid   = 4'b0001;
        inp_data[0] = 8'hA0;
        oup_ready   = 1'b1;
        #1;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_no_fallthrough: got %b expected 0", oup_valid); end
        checks++; if (inp_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b expected 1", inp_ready[0]); end
        tick();
        inp_valid = '0;
        #1;
        checks++; if (oup_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", oup_valid); end
        checks++; if (oup_data !== 8'hA0) begin errors++; $display("[TB] FAIL single_data: got %h expected a0", oup_data); end
        checks++; if (oup_idx !== 2'd0) begin errors++; $display("[TB] FAIL single_idx: got %0d expected 0", oup_idx); end
        checks++; if (usage[0] !== 2'd1) begin errors++; $display("[TB] FAIL single_usage_one: got %0d expected 1", usage[0]); end
        tick();
        #1;
        checks++; if (usage[0] !== 2'd0) begin errors++; $display("[TB] FAIL single_usage_zero: got %0d expected 0", usage[0]); end
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drained: got %b expected 0", oup_valid); end
    endtask

    task automatic test_round_robin();
        do_flush();
        inp_valid = 4'b1110;
        inp_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        tick();
        inp_valid = '0;
        oup_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (oup_valid !== 1'b1) begin errors++; $display("[TB] FAIL rr_valid step %0d: got %b expected 1", k, oup_valid); end
            checks++; if (oup_idx !== 2'(k)) begin errors++; $display("[TB] FAIL rr_idx step %0d: got %0d expected %0d", k, oup_idx, k); end
            checks++; if (oup_data !== 8'(8'h11 * k)) begin errors++; $display("[TB] FAIL rr_data step %0d: got %h expected %h", k, oup_data, 8'(8'h11 * k)); end
            tick();
        end
        #1;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_drained: got %b expected 0", oup_valid); end
    endtask

    task automatic test_full();
        data_t words [3];
        words[0] = 8'h11;
        words[1] = 8'h22;
        words[2] = 8'h33;
        do_flush();
        for (int k = 0; k < 3; k++) begin
            inp_valid   = 4'b0100;
            inp_data[2] = words[k];
            #1;
            checks++; if (inp_ready[2] !== (k < 2)) begin errors++; $display("[TB] FAIL full_ready push %0d: got %b expected %b", k, inp_ready[2], (k < 2)); end
            tick();
        end
        inp_valid = '0;
        #1;
        checks++; if (usage[2] !== 2'd2) begin errors++; $display("[TB] FAIL full_usage: got %0d expected 2", usage[2]); end
        oup_ready = 1'b1;
        checks++; if (oup_data !== 8'h11) begin errors++; $display("[TB] FAIL full_first: got %h expected 11", oup_data); end
        tick();
        #1;
        checks++; if (oup_data !== 8'h22) begin errors++; $display("[TB] FAIL full_second: got %h expected 22", oup_data); end
        tick();
        #1;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_rejected: got %b expected 0", oup_valid); end
    endtask

    task automatic test_lock();
        do_flush();
        inp_valid   = 4'b1000;
        inp_data[3] = 8'h3C;
        tick();
        for (int k = 0; k < 3; k++) begin
            inp_valid   = (k < 2) ? 4'b0001 : 4'b0000;
            inp_data[0] = 8'hC0 + 8'(k);
            #1;
            checks++; if (oup_idx !== 2'd3) begin errors++; $display("[TB] FAIL lock_idx cycle %0d: got %0d expected 3", k, oup_idx); end
            checks++; if (oup_data !== 8'h3C) begin errors++; $display("[TB] FAIL lock_data cycle %0d: got %h expected 3c", k, oup_data); end
            tick();
        end
        inp_valid = '0;
        oup_ready = 1'b1;
        #1;
        checks++; if (oup_idx !== 2'd3) begin errors++; $display("[TB] FAIL lock_release_idx: got %0d expected 3", oup_idx); end
        tick();
        #1;
        checks++; if (oup_idx !== 2'd0) begin errors++; $display("[TB] FAIL lock_next_idx: got %0d expected 0", oup_idx); end
        checks++; if (oup_data !== 8'hC0) begin errors++; $display("[TB] FAIL lock_next_data: got %h expected c0", oup_data); end
    endtask

    task automatic test_flush();
        do_flush();
        inp_valid   = 4'b0010;
        inp_data[1] = 8'h5A;
        tick();
        inp_valid = '0;
        oup_ready = 1'b1;
        tick();
        oup_ready = 1'b0;
        inp_valid = 4'b0111;
        inp_data  = {8'h00, 8'h23, 8'h13, 8'h03};
        tick();
        inp_valid = 4'b0011;
        tick();
        inp_valid = '0;
        #1;
        checks++; if (usage !== {2'd0, 2'd1, 2'd2, 2'd2}) begin errors++; $display("[TB] FAIL flush_fill: got %h expected 1a", usage); end
        flush = 1'b1;
        #1;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid_low: got %b expected 0", oup_valid); end
        checks++; if (inp_ready !== 4'h0) begin errors++; $display("[TB] FAIL flush_ready_low: got %b expected 0000", inp_ready); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (usage !== '0) begin errors++; $display("[TB] FAIL flush_usage: got %h expected 0", usage); end
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty: got %b expected 0", oup_valid); end
        inp_valid   = 4'b1001;
        inp_data[0] = 8'hE0;
        inp_data[3] = 8'hE3;
        tick();
        inp_valid = '0;
        #1;
        checks++; if (oup_idx !== 2'd0) begin errors++; $display("[TB] FAIL flush_ptr_idx: got %0d expected 0", oup_idx); end
        checks++; if (oup_data !== 8'hE0) begin errors++; $display("[TB] FAIL flush_ptr_data: got %h expected e0", oup_data); end
    endtask

    task automatic test_reset_mid();
        do_flush();
        inp_valid = 4'b0110;
        inp_data  = {8'h00, 8'h62, 8'h61, 8'h00};
        tick();
        inp_valid = '0;
        #1;
        checks++; if (oup_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_before: got %b expected 1", oup_valid); end
        #2;
        rst_n     = 1'b0;
        oup_ready = 1'b1;
        #1;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", oup_valid); end
        checks++; if (usage !== '0) begin errors++; $display("[TB] FAIL midrst_usage: got %h expected 0", usage); end
        checks++; if (oup_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 00", oup_data); end
        #10;
        rst_n = 1'b1;
        tick();
        #1;
        checks++; if (oup_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_after_valid: got %b expected 0", oup_valid); end
        checks++; if (usage !== '0) begin errors++; $display("[TB] FAIL midrst_after_usage: got %h expected 0", usage); end
        checks++; if (inp_ready !== 4'hF) begin errors++; $display("[TB] FAIL midrst_after_ready: got %b expected 1111", inp_ready); end
        oup_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [NCH-1:0]      exp_ready;
        logic [NCH-1:0][1:0] exp_usage;
        logic                exp_valid;
        logic [1:0]          exp_idx;
        data_t               exp_data;
        data_t               dropped;
        int                  sel;
        do_flush();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_ptr     = 0;
        m_held    = 1'b0;
        m_held_ch = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            inp_valid = 4'($urandom);
            for (int c = 0; c < NCH; c++) inp_data[c] = 8'($urandom);
            oup_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            #1;
            // A word shown but not taken must stay on the output; otherwise scan from the pointer.
            sel = -1;
            if (!flush) begin
                if (m_held) begin
                    sel = m_held_ch;
                end else begin
                    for (int i = 0; i < NCH; i++) begin
                        int c;
                        c = (m_ptr + i) % NCH;
                        if (sel < 0 && mq[c].size() > 0) sel = c;
                    end
                end
            end
            exp_valid = (sel >= 0);
            exp_idx   = 2'd0;
            exp_data  = 8'h00;
            if (exp_valid) begin
                exp_idx  = 2'(sel);
                exp_data = mq[sel][0];
            end
            for (int c = 0; c < NCH; c++) begin
                exp_ready[c] = !flush && (mq[c].size() < DEP);
                exp_usage[c] = 2'(mq[c].size());
            end
            checks++; if (inp_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready cycle %0d: got %b expected %b", cyc, inp_ready, exp_ready); end
            checks++; if (oup_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid cycle %0d: got %b expected %b", cyc, oup_valid, exp_valid); end
            checks++; if (oup_idx !== exp_idx) begin errors++; $display("[TB] FAIL rnd_idx cycle %0d: got %0d expected %0d", cyc, oup_idx, exp_idx); end
            checks++; if (oup_data !== exp_data) begin errors++; $display("[TB] FAIL rnd_data cycle %0d: got %h expected %h", cyc, oup_data, exp_data); end
            checks++; if (usage !== exp_usage) begin errors++; $display("[TB] FAIL rnd_usage cycle %0d: got %h expected %h", cyc, usage, exp_usage); end
            if (flush) begin
                for (int c = 0; c < NCH; c++) mq[c].delete();
                m_ptr  = 0;
                m_held = 1'b0;
            end else begin
                if (exp_valid && oup_ready) begin
                    dropped = mq[sel].pop_front();
                    m_ptr   = (sel + 1) % NCH;
                end
                m_held    = exp_valid && !oup_ready;
                m_held_ch = sel;
                for (int c = 0; c < NCH; c++) begin
                    if (inp_valid[c] && exp_ready[c]) mq[c].push_back(inp_data[c]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_push();
        test_round_robin();
        test_full();
        test_lock();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo_arb.md
STREAM_FIFO_ARB -- requirements
Module: stream_fifo_arb

Interface
REQ-001 SHALL have parameter NumChan, default 4, number of input stream channels (>=1).
REQ-002 SHALL have parameter Depth, default 4, entries per channel FIFO (>=1).
REQ-003 SHALL have parameter type T, default logic, payload type.
REQ-004 SHALL have localparams IdxWidth = max(1, clog2(NumChan)) and CntWidth = clog2(Depth+1).
REQ-005 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: flush_i  in  1  synchronous clear of all channels.
REQ-007 SHALL have ports: inp_data_i  in  NumChan x T  per-channel payload; inp_valid_i  in  NumChan  per-channel valid; inp_ready_o  out  NumChan  per-channel ready.
REQ-008 SHALL have ports: oup_data_o  out  T  merged payload; oup_idx_o  out  IdxWidth  source channel; oup_valid_o  out  1; oup_ready_i  in  1.
REQ-009 SHALL have ports: usage_o  out  NumChan x CntWidth  per-channel fill level.

Function
REQ-010 SHALL hold one independent FIFO of Depth entries per channel; capacity exactly Depth.
REQ-011 SHALL drive inp_ready_o[c] = !full[c] from state only, with no combinational path from inp_valid_i.
REQ-012 SHALL push on channel c when inp_valid_i[c] && inp_ready_o[c].
REQ-013 SHALL NOT fall through: a word pushed in cycle t appears on output no earlier than t+1.
REQ-014 SHALL assert oup_valid_o when the selected channel is non-empty; oup_data_o/oup_idx_o give its head word and index.
REQ-015 SHALL pop the selected channel on oup_valid_o && oup_ready_i.
REQ-016 SHALL arbitrate round-robin: pointer resets to 0; select first non-empty channel at or after pointer, wrapping mod NumChan.
REQ-017 SHALL advance the pointer to (k+1) mod NumChan after an output handshake on channel k; unchanged otherwise.
REQ-018 SHALL lock selection while oup_valid_o && !oup_ready_i, so oup_data_o, oup_idx_o stay stable until handshake, even if a higher-priority channel fills.
REQ-019 SHALL keep usage_o[c] unchanged on a same-cycle push and pop of channel c; +1 on push only, -1 on pop only.
REQ-020 SHALL NOT accept a push into a full channel even if that channel is popped in the same cycle.
REQ-021 SHALL, on flush_i, force inp_ready_o and oup_valid_o low that cycle, discard all entries, zero usage_o, clear lock, set pointer to 0 at the next edge.
REQ-022 SHALL with NumChan=1 behave as a plain FIFO with oup_idx_o constant 0.

Reset
REQ-023 SHALL on rst_ni low asynchronously empty all FIFOs, pointer=0, lock cleared.
REQ-024 SHALL during and after reset drive oup_valid_o=0, usage_o=0, inp_ready_o all 1 once rst_ni is high; oup_data_o/oup_idx_o SHALL be 0.
REQ-025 SHALL discard in-flight data when reset asserts mid-operation; no output handshake completes in a reset cycle.

Structure
REQ-026 SHALL need no shared package; parameters local to the module.
REQ-027 SHALL instantiate fifo_v3 (FALL_THROUGH=0, DEPTH=Depth, dtype=T) per channel, flush_i wired to its flush.
REQ-028 SHALL implement the round-robin pointer, lock register and output mux in this module.
REQ-029 SHALL check at elaboration: NumChan>=1, Depth>=1.

Verification (NumChan=4, Depth=2, T=logic[7:0])
REQ-030 SHALL cover: push 0xA0 ch0 cycle 1, oup_ready_i=1 -> oup_valid_o=1, data 0xA0, idx 0 in cycle 2; usage_o[0] 1 then 0.
REQ-031 SHALL cover: ch1..3 each hold 1 word, ch0 empty, oup_ready_i=1 -> output order idx 1,2,3, one per cycle.
REQ-032 SHALL cover: ch2 pushes 0x11,0x22,0x33, no pop -> inp_ready_o[2]=0 after 2 pushes, 0x33 rejected, usage_o[2]=2.
REQ-033 SHALL cover: ch3 valid with oup_ready_i=0 for 3 cycles while ch0 fills -> idx stays 3, data stable, ch0 served next.
REQ-034 SHALL cover: flush_i pulse with 5 words stored -> next cycle usage_o all 0, oup_valid_o=0, pointer 0.
REQ-035 SHALL cover: rst_ni low mid-stream for 1 cycle -> oup_valid_o=0 immediately, all FIFOs empty after release.
